// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares the single iob-cache native port between the
// host bus, the LSU load channel and the LSU store channel, one transaction at a time.
module mem_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 22
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic                    host_req,
   input  logic                    host_we,
   input  logic [ADDR_WIDTH-1:0]   host_addr,
   input  logic [DATA_WIDTH-1:0]   host_wdata,
   input  logic [DATA_WIDTH/8-1:0] host_wstrb,
   output logic [DATA_WIDTH-1:0]   host_rdata,
   output logic                    host_complete,
   input  logic                    load_req,
   input  logic [ADDR_WIDTH-1:0]   load_addr,
   output logic [DATA_WIDTH-1:0]   load_data,
   output logic                    load_complete,
   input  logic                    store_req,
   input  logic [ADDR_WIDTH-1:0]   store_addr,
   input  logic [DATA_WIDTH-1:0]   store_data,
   output logic                    store_complete,
   output logic                    iob_valid_o,
   output logic [ADDR_WIDTH-1:0]   iob_addr_o,
   output logic [DATA_WIDTH-1:0]   iob_wdata_o,
   output logic [DATA_WIDTH/8-1:0] iob_wstrb_o,
   input  logic                    iob_ready_i,
   input  logic                    iob_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   iob_rdata_i,
   output logic                    busy_o
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_RESP} state_e;
   typedef enum logic [1:0] {CH_HOST = 2'd0, CH_LOAD = 2'd1, CH_STORE = 2'd2} chan_e;

   state_e state_q, state_d;
   chan_e  grant_q, grant_d, last_q, last_d, pick;

   logic [2:0] req_q, req_d, pending_q, pending_d;
   logic [2:0] rise, clear, accept;
   logic       capture, is_read;

   logic [ADDR_WIDTH-1:0] addr_q  [3];
   logic [ADDR_WIDTH-1:0] addr_d  [3];
   logic [DATA_WIDTH-1:0] wdata_q [3];
   logic [DATA_WIDTH-1:0] wdata_d [3];
   logic [STRB_WIDTH-1:0] wstrb_q [3];
   logic [STRB_WIDTH-1:0] wstrb_d [3];

   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
   logic [DATA_WIDTH-1:0] load_data_q, load_data_d;

   // Search order starts just after the previous winner.
   always_comb begin
      pick = CH_HOST;
      case (last_q)
         CH_HOST: pick = pending_q[1] ? CH_LOAD  : (pending_q[2] ? CH_STORE : CH_HOST);
         CH_LOAD: pick = pending_q[2] ? CH_STORE : (pending_q[0] ? CH_HOST  : CH_LOAD);
         default: pick = pending_q[0] ? CH_HOST  : (pending_q[1] ? CH_LOAD  : CH_STORE);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_d       = last_q;
      clear        = '0;
      capture      = 1'b0;
      host_rdata_d = host_rdata_q;
      load_data_d  = load_data_q;
      req_d        = {store_req, load_req, host_req};
      rise         = req_d & ~req_q;
      is_read      = (wstrb_q[grant_q] == '0);

      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               grant_d = pick;
               last_d  = pick;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (iob_ready_i) begin
               if (!is_read) begin
                  state_d = S_RESP;
               end else if (iob_rvalid_i) begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT_R;
               end
            end
         end
         S_WAIT_R: begin
            if (iob_rvalid_i) begin
               capture = 1'b1;
               state_d = S_RESP;
            end
         end
         default: begin
            clear[grant_q] = 1'b1;
            state_d        = S_IDLE;
         end
      endcase

      if (capture) begin
         if (grant_q == CH_HOST) host_rdata_d = iob_rdata_i;
         if (grant_q == CH_LOAD) load_data_d  = iob_rdata_i;
      end

      // An edge arriving while its channel is being retired is kept (set beats clear).
      accept    = rise & (~pending_q | clear);
      pending_d = accept | (pending_q & ~clear);

      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      if (accept[0]) begin
         addr_d[0]  = host_addr;
         wdata_d[0] = host_wdata;
         wstrb_d[0] = host_we ? host_wstrb : '0;
      end
      if (accept[1]) begin
         addr_d[1]  = load_addr;
         wdata_d[1] = '0;
         wstrb_d[1] = '0;
      end
      if (accept[2]) begin
         addr_d[2]  = store_addr;
         wdata_d[2] = store_data;
         wstrb_d[2] = '1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q      <= S_IDLE;
         grant_q      <= CH_HOST;
         last_q       <= CH_STORE;
         req_q        <= '0;
         pending_q    <= '0;
         host_rdata_q <= '0;
         load_data_q  <= '0;
         for (int unsigned i = 0; i < 3; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            wstrb_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_q       <= last_d;
         req_q        <= req_d;
         pending_q    <= pending_d;
         host_rdata_q <= host_rdata_d;
         load_data_q  <= load_data_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
      end
   end

   assign iob_valid_o    = (state_q == S_ISSUE);
   assign iob_addr_o     = iob_valid_o ? addr_q[grant_q]  : '0;
   assign iob_wdata_o    = iob_valid_o ? wdata_q[grant_q] : '0;
   assign iob_wstrb_o    = iob_valid_o ? wstrb_q[grant_q] : '0;
   assign busy_o         = (state_q != S_IDLE);
   assign host_complete  = (state_q == S_RESP) && (grant_q == CH_HOST);
   assign load_complete  = (state_q == S_RESP) && (grant_q == CH_LOAD);
   assign store_complete = (state_q == S_RESP) && (grant_q == CH_STORE);
   assign host_rdata     = host_rdata_q;
   assign load_data      = load_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a behavioural cache responder plus a
// round-robin reference model predicting grant order, contents and read data.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 22;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          arst_i = 1'b1;
   logic          host_req = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic [SW-1:0] host_wstrb = '0;
   logic [DW-1:0] host_rdata;
   logic          host_complete;
   logic          load_req = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [DW-1:0] load_data;
   logic          load_complete;
   logic          store_req = 1'b0;
   logic [AW-1:0] store_addr = '0;
   logic [DW-1:0] store_data = '0;
   logic          store_complete;
   logic          iob_valid_o;
   logic [AW-1:0] iob_addr_o;
   logic [DW-1:0] iob_wdata_o;
   logic [SW-1:0] iob_wstrb_o;
   logic          iob_ready_i = 1'b0, iob_rvalid_i = 1'b0;
   logic [DW-1:0] iob_rdata_i = '0;
   logic          busy_o;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .arst_i(arst_i),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_rdata(host_rdata),
      .host_complete(host_complete),
      .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
      .load_complete(load_complete),
      .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
      .store_complete(store_complete),
      .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
      .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
      .iob_rdata_i(iob_rdata_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;

   // Cache responder knobs and transaction log
   int  ready_delay = 0, rv_delay = 0;
   bit  use_fixed = 1'b0, noise = 1'b0;
   logic [DW-1:0] fixed_rdata = '0;
   logic [AW-1:0] t_addr[$];
   logic [DW-1:0] t_wdata[$];
   logic [SW-1:0] t_wstrb[$];
   int  unstable = 0;

   // Completion log
   int  comp_ch[$];
   int  comp_cyc[$];
   logic [DW-1:0] comp_data[$];
   int  overlap = 0, wr_cnt = 0;

   function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
      return {a[9:0], 22'h0} ^ {10'h0, a} ^ 32'h5A5A_1234;
   endfunction

   initial begin : responder
      int wait_cnt = 0, rv_cnt = 0;
      bit tracking = 1'b0, rv_pending = 1'b0;
      logic [DW-1:0] rv_val = '0;
      logic [AW-1:0] s_addr = '0;
      logic [DW-1:0] s_wdata = '0;
      logic [SW-1:0] s_wstrb = '0;
      forever begin
         @(posedge clk); #1;
         iob_ready_i  = 1'b0;
         iob_rvalid_i = 1'b0;
         iob_rdata_i  = $urandom;
         if (arst_i) begin
            wait_cnt = 0; tracking = 1'b0; rv_pending = 1'b0;
            continue;
         end
         if (rv_pending) begin
            if (rv_cnt == 0) begin
               iob_rvalid_i = 1'b1; iob_rdata_i = rv_val; rv_pending = 1'b0;
            end else rv_cnt--;
         end else if (iob_valid_o) begin
            if (!tracking) begin
               tracking = 1'b1; s_addr = iob_addr_o; s_wdata = iob_wdata_o; s_wstrb = iob_wstrb_o;
            end else if (s_addr !== iob_addr_o || s_wdata !== iob_wdata_o || s_wstrb !== iob_wstrb_o) begin
               unstable++;
            end
            if (wait_cnt < ready_delay) wait_cnt++;
            else begin
               iob_ready_i = 1'b1; wait_cnt = 0; tracking = 1'b0;
               t_addr.push_back(iob_addr_o); t_wdata.push_back(iob_wdata_o); t_wstrb.push_back(iob_wstrb_o);
               if (iob_wstrb_o == '0) begin
                  rv_val = use_fixed ? fixed_rdata : rd_fn(iob_addr_o);
                  if (rv_delay == 0) begin
                     iob_rvalid_i = 1'b1; iob_rdata_i = rv_val;
                  end else begin
                     rv_pending = 1'b1; rv_cnt = rv_delay - 1;
                  end
               end
            end
         end else if (noise && !busy_o) begin
            iob_rvalid_i = 1'($urandom_range(0, 1));
         end
      end
   end

   always @(negedge clk) begin
      if (!arst_i) begin
         if (32'(host_complete) + 32'(load_complete) + 32'(store_complete) > 1) overlap++;
         if (host_complete)  begin comp_ch.push_back(0); comp_cyc.push_back(cyc); comp_data.push_back(host_rdata); end
         if (load_complete)  begin comp_ch.push_back(1); comp_cyc.push_back(cyc); comp_data.push_back(load_data); end
         if (store_complete) begin comp_ch.push_back(2); comp_cyc.push_back(cyc); comp_data.push_back('0); end
         if (busy_o && !iob_valid_o && !host_complete && !load_complete && !store_complete) wr_cnt++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_logs();
      comp_ch.delete(); comp_cyc.delete(); comp_data.delete();
      t_addr.delete(); t_wdata.delete(); t_wstrb.delete();
      unstable = 0; overlap = 0; wr_cnt = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      arst_i = 1'b1; host_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 arst_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse(input bit h, input bit l, input bit s, output int drv);
      @(posedge clk); #1;
      host_req = h; load_req = l; store_req = s;
      drv = cyc;
      @(posedge clk); #1;
      host_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
   endtask

   task automatic wait_comp(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (comp_ch.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic settle();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst_i = 1'b1;
      #3;
      n_cmp++;
      if ({iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, busy_o, host_complete,
           load_complete, store_complete, host_rdata, load_data} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got nonzero output (valid=%b busy=%b) expected all 0", iob_valid_o, busy_o);
      end
      do_reset();
      clear_logs();
      settle();
      n_cmp++;
      if (busy_o !== 1'b0 || iob_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle: got busy=%b valid=%b expected 0 0", busy_o, iob_valid_o);
      end
      n_cmp++;
      if (comp_ch.size() != 0) begin
         n_bad++; $display("FAIL reset_no_complete: got %0d completions expected 0", comp_ch.size());
      end
   endtask

   task automatic test_simultaneous();
      int k; bit ok;
      do_reset(); clear_logs();
      ready_delay = 0; rv_delay = 0; use_fixed = 1'b0;
      host_we = 1'b1; host_addr = AW'($urandom); host_wdata = $urandom; host_wstrb = SW'($urandom_range(1, 15));
      load_addr = AW'($urandom); store_addr = AW'($urandom); store_data = $urandom;
      pulse(1'b1, 1'b1, 1'b1, k);
      wait_comp(3, 80, ok);
      settle();
      n_cmp++;
      if (!ok || comp_ch.size() != 3 || t_addr.size() != 3) begin
         n_bad++; $display("FAIL simul_count: got %0d completions expected 3", comp_ch.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (comp_ch[i] !== i) begin n_bad++; $display("FAIL simul_order[%0d]: got %0d expected %0d", i, comp_ch[i], i); end
         end
         n_cmp++;
         if (overlap != 0) begin n_bad++; $display("FAIL simul_overlap: got %0d expected 0", overlap); end
         n_cmp++;
         if (t_addr[0] !== host_addr || t_wdata[0] !== host_wdata || t_wstrb[0] !== host_wstrb) begin
            n_bad++; $display("FAIL simul_host_txn: got %h/%h/%h expected %h/%h/%h", t_addr[0], t_wdata[0], t_wstrb[0], host_addr, host_wdata, host_wstrb);
         end
         n_cmp++;
         if (t_addr[1] !== load_addr || t_wstrb[1] !== '0 || comp_data[1] !== rd_fn(load_addr)) begin
            n_bad++; $display("FAIL simul_load_txn: got %h/%h data %h expected %h/0 data %h", t_addr[1], t_wstrb[1], comp_data[1], load_addr, rd_fn(load_addr));
         end
         n_cmp++;
         if (t_addr[2] !== store_addr || t_wdata[2] !== store_data || t_wstrb[2] !== 4'hF) begin
            n_bad++; $display("FAIL simul_store_txn: got %h/%h/%h expected %h/%h/f", t_addr[2], t_wdata[2], t_wstrb[2], store_addr, store_data);
         end
      end
   endtask

   task automatic test_single_load();
      int k; bit ok;
      clear_logs();
      ready_delay = 0; rv_delay = 0; use_fixed = 1'b1; fixed_rdata = 32'h0102_0304;
      load_addr = '0;
      pulse(1'b0, 1'b1, 1'b0, k);
      wait_comp(1, 40, ok);
      settle();
      n_cmp++;
      if (!ok || comp_ch.size() != 1 || t_addr.size() != 1) begin
         n_bad++; $display("FAIL load_count: got %0d completions expected 1", comp_ch.size());
      end else begin
         n_cmp++;
         if (comp_ch[0] !== 1) begin n_bad++; $display("FAIL load_chan: got %0d expected 1", comp_ch[0]); end
         n_cmp++;
         if (comp_cyc[0] - k !== 3) begin n_bad++; $display("FAIL load_latency: got %0d expected 3", comp_cyc[0] - k); end
         n_cmp++;
         if (comp_data[0] !== 32'h0102_0304) begin n_bad++; $display("FAIL load_data: got %h expected 01020304", comp_data[0]); end
         n_cmp++;
         if (t_wstrb[0] !== '0 || t_addr[0] !== '0) begin n_bad++; $display("FAIL load_txn: got addr %h strb %h expected 0 0", t_addr[0], t_wstrb[0]); end
         n_cmp++;
         if (load_data !== 32'h0102_0304) begin n_bad++; $display("FAIL load_data_hold: got %h expected 01020304", load_data); end
      end
      use_fixed = 1'b0;
   endtask

   task automatic test_single_store();
      int k; bit ok;
      clear_logs();
      ready_delay = 2; rv_delay = 0;
      store_addr = AW'(4); store_data = 32'h0000_000A;
      pulse(1'b0, 1'b0, 1'b1, k);
      wait_comp(1, 40, ok);
      settle();
      n_cmp++;
      if (!ok || comp_ch.size() != 1 || t_addr.size() != 1) begin
         n_bad++; $display("FAIL store_count: got %0d completions expected 1", comp_ch.size());
      end else begin
         n_cmp++;
         if (comp_ch[0] !== 2) begin n_bad++; $display("FAIL store_chan: got %0d expected 2", comp_ch[0]); end
         n_cmp++;
         if (t_wstrb[0] !== 4'hF || t_wdata[0] !== 32'hA || t_addr[0] !== AW'(4)) begin
            n_bad++; $display("FAIL store_txn: got %h/%h/%h expected 4/a/f", t_addr[0], t_wdata[0], t_wstrb[0]);
         end
         n_cmp++;
         if (unstable != 0) begin n_bad++; $display("FAIL store_stable: got %0d changes expected 0", unstable); end
         n_cmp++;
         if (comp_cyc[0] - k !== 5) begin n_bad++; $display("FAIL store_latency: got %0d expected 5", comp_cyc[0] - k); end
      end
      ready_delay = 0;
   endtask

   task automatic test_fairness();
      int k, nl, ns; bit ok;
      clear_logs();
      ready_delay = 0; rv_delay = 1;
      load_addr = AW'($urandom); store_addr = AW'($urandom); store_data = $urandom;
      pulse(1'b0, 1'b1, 1'b1, k);
      for (int r = 0; r < 6; r++) begin
         wait_comp(r + 1, 60, ok);
         if (!ok) break;
         if (r < 4) pulse(1'b0, comp_ch[r] == 1, comp_ch[r] == 2, k);
      end
      settle();
      n_cmp++;
      if (comp_ch.size() != 6) begin
         n_bad++; $display("FAIL fair_count: got %0d completions expected 6", comp_ch.size());
      end else begin
         nl = 0; ns = 0;
         for (int i = 0; i < 6; i++) begin
            if (comp_ch[i] == 1) nl++;
            if (comp_ch[i] == 2) ns++;
            if (i > 0) begin
               n_cmp++;
               if (comp_ch[i] === comp_ch[i-1]) begin n_bad++; $display("FAIL fair_alternate[%0d]: got %0d twice expected alternation", i, comp_ch[i]); end
            end
         end
         n_cmp++;
         if (nl != 3 || ns != 3) begin n_bad++; $display("FAIL fair_split: got load %0d store %0d expected 3 3", nl, ns); end
      end
      rv_delay = 0;
   endtask

   task automatic test_held_level();
      bit ok;
      clear_logs();
      ready_delay = 1; rv_delay = 0;
      load_addr = AW'($urandom);
      @(posedge clk); #1 load_req = 1'b1;
      repeat (10) @(posedge clk);
      #1 load_req = 1'b0;
      wait_comp(1, 40, ok);
      settle(); settle();
      n_cmp++;
      if (comp_ch.size() != 1 || t_addr.size() != 1) begin
         n_bad++; $display("FAIL held_count: got %0d completions %0d txns expected 1 1", comp_ch.size(), t_addr.size());
      end else begin
         n_cmp++;
         if (comp_ch[0] !== 1 || comp_data[0] !== rd_fn(load_addr)) begin
            n_bad++; $display("FAIL held_data: got ch %0d data %h expected 1 %h", comp_ch[0], comp_data[0], rd_fn(load_addr));
         end
      end
      ready_delay = 0;
   endtask

   task automatic test_wait_read_then_reset();
      int k; bit ok, seen;
      clear_logs();
      ready_delay = 1; rv_delay = 4;
      load_addr = AW'($urandom);
      pulse(1'b0, 1'b1, 1'b0, k);
      wait_comp(1, 60, ok);
      settle();
      n_cmp++;
      if (!ok || comp_ch.size() != 1) begin
         n_bad++; $display("FAIL waitr_count: got %0d completions expected 1", comp_ch.size());
      end else begin
         n_cmp++;
         if (comp_cyc[0] - k !== 8) begin n_bad++; $display("FAIL waitr_latency: got %0d expected 8", comp_cyc[0] - k); end
         n_cmp++;
         if (comp_data[0] !== rd_fn(load_addr)) begin n_bad++; $display("FAIL waitr_data: got %h expected %h", comp_data[0], rd_fn(load_addr)); end
         n_cmp++;
         if (wr_cnt != 4) begin n_bad++; $display("FAIL waitr_cycles: got %0d expected 4", wr_cnt); end
      end

      clear_logs();
      ready_delay = 30; rv_delay = 0;
      store_addr = AW'($urandom); store_data = $urandom;
      pulse(1'b0, 1'b0, 1'b1, k);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (iob_valid_o === 1'b1);
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rst_issue_reach: got valid=%b expected 1", iob_valid_o); end
      @(posedge clk); #1 arst_i = 1'b1;
      #2;
      n_cmp++;
      if ({iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, busy_o, host_complete,
           load_complete, store_complete, host_rdata, load_data} !== '0) begin
         n_bad++; $display("FAIL rst_mid_outputs: got valid=%b busy=%b load_data=%h expected all 0", iob_valid_o, busy_o, load_data);
      end
      ready_delay = 0;
      @(posedge clk); #1 arst_i = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      n_cmp++;
      if (comp_ch.size() != 0 || busy_o !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid_abort: got %0d completions busy=%b expected 0 0", comp_ch.size(), busy_o);
      end
   endtask

   task automatic test_random();
      int k, n, m_last; bit ok;
      int exp_ch[$];
      logic [AW-1:0] e_addr [3];
      logic [DW-1:0] e_wdata[3];
      logic [SW-1:0] e_strb [3];
      logic [2:0] mask;
      m_last = 2;
      noise = 1'b1;
      for (int r = 0; r < 25; r++) begin
         clear_logs();
         exp_ch.delete();
         mask = 3'($urandom_range(1, 7));
         ready_delay = $urandom_range(0, 3); rv_delay = $urandom_range(0, 3);
         host_we = 1'($urandom_range(0, 1)); host_addr = AW'($urandom); host_wdata = $urandom;
         host_wstrb = SW'($urandom_range(1, 15));
         load_addr = AW'($urandom); store_addr = AW'($urandom); store_data = $urandom;
         e_addr[0] = host_addr;  e_wdata[0] = host_wdata; e_strb[0] = host_we ? host_wstrb : '0;
         e_addr[1] = load_addr;  e_wdata[1] = '0;         e_strb[1] = '0;
         e_addr[2] = store_addr; e_wdata[2] = store_data; e_strb[2] = '1;
         for (int j = 1; j <= 3; j++) if (mask[(m_last + j) % 3]) exp_ch.push_back((m_last + j) % 3);
         n = exp_ch.size();
         pulse(mask[0], mask[1], mask[2], k);
         wait_comp(n, 100, ok);
         settle();
         n_cmp++;
         if (!ok || comp_ch.size() != n || t_addr.size() != n || overlap != 0) begin
            n_bad++; $display("FAIL rand%0d_count: got %0d completions overlap %0d expected %0d 0", r, comp_ch.size(), overlap, n);
            break;
         end
         for (int i = 0; i < n; i++) begin
            int c;
            c = exp_ch[i];
            n_cmp++;
            if (comp_ch[i] !== c) begin n_bad++; $display("FAIL rand%0d_order[%0d]: got %0d expected %0d", r, i, comp_ch[i], c); end
            n_cmp++;
            if (t_addr[i] !== e_addr[c] || t_wstrb[i] !== e_strb[c]) begin
               n_bad++; $display("FAIL rand%0d_txn[%0d]: got %h/%h expected %h/%h", r, i, t_addr[i], t_wstrb[i], e_addr[c], e_strb[c]);
            end
            n_cmp++;
            if (e_strb[c] != '0) begin
               if (t_wdata[i] !== e_wdata[c]) begin n_bad++; $display("FAIL rand%0d_wdata[%0d]: got %h expected %h", r, i, t_wdata[i], e_wdata[c]); end
            end else if (comp_data[i] !== rd_fn(e_addr[c])) begin
               n_bad++; $display("FAIL rand%0d_rdata[%0d]: got %h expected %h", r, i, comp_data[i], rd_fn(e_addr[c]));
            end
         end
         m_last = exp_ch[n-1];
      end
      noise = 1'b0;
   endtask

   initial begin
      test_reset();
      test_simultaneous();
      test_single_load();
      test_single_store();
      test_fairness();
      test_held_level();
      test_wait_read_then_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
